// File: rtl/ascon_pack.sv
`default_nettype none
// ============================================================================
//  Module : ascon_pack
//  Brief  : Shared types and constants for the ASCON data absorber.
//  Rev    : 1.0  initial release
// ============================================================================
package ascon_pack;

   // Five 64-bit words of ASCON state; word 0 is the rate word.
   typedef logic [4:0][63:0] type_state;

   // Byte appended directly after the last valid message byte.
   localparam logic [7:0]  c_pad_byte = 8'h80;

   // Padding word used when the last block is completely full.
   localparam logic [63:0] c_pad_word = {c_pad_byte, 56'h0};

endpackage : ascon_pack
`default_nettype wire

// File: rtl/data_absorber_pad_mask.sv
`default_nettype none
// ============================================================================
//  Module : pad_mask
//  Brief  : Builds the padded absorb word and the valid-byte mask of a block.
//           Non-last blocks, and last blocks of 8 bytes, pass through
//           unpadded with a full mask.
//  Rev    : 1.0  initial release
// ============================================================================
module pad_mask
   import ascon_pack::*;
(
   input  logic [63:0] data,
   input  logic [3:0]  bytes,
   input  logic        last,
   output logic [63:0] padded,
   output logic [63:0] mask
);

   logic [3:0] n_valid;

   // Out-of-range byte counts (0 or above 8) behave like a full block.
   assign n_valid = (!last || bytes == 4'd0 || bytes > 4'd8) ? 4'd8 : bytes;

   // Per-byte selection: keep valid bytes, drop in the pad byte, zero the rest.
   always_comb begin
      padded = '0;
      mask   = '0;
      for (int i = 0; i < 8; i++) begin
         if (4'(i) < n_valid) begin
            padded[63-8*i -: 8] = data[63-8*i -: 8];
            mask[63-8*i -: 8]   = 8'hFF;
         end else if (4'(i) == n_valid) begin
            padded[63-8*i -: 8] = c_pad_byte;
         end
      end
   end

endmodule : pad_mask
`default_nettype wire

// File: rtl/data_absorber.sv
`default_nettype none
// ============================================================================
//  Module : data_absorber
//  Brief  : Absorbs associated data and plaintext into an external ASCON
//           state, emits ciphertext, requests permutations and applies the
//           finalization key XOR.
//  Rev    : 1.0  initial release
// ============================================================================
module data_absorber
   import ascon_pack::*;
#(
   parameter bit FIN_KEY_EN = 1'b1
) (
   input  logic          clock_i,
   input  logic          resetb_i,
   input  logic          start_i,
   input  logic          noad_i,
   input  logic [127:0]  key_i,
   input  logic [63:0]   data_i,
   input  logic          data_valid_i,
   input  logic          data_last_i,
   input  logic [3:0]    data_bytes_i,
   output logic          data_ready_o,
   input  type_state     state_i,
   output type_state     state_o,
   output logic          state_we_o,
   output logic          perm_start_o,
   input  logic          perm_done_i,
   output logic [63:0]   cipher_o,
   output logic          cipher_valid_o,
   output logic          ad_done_o,
   output logic          fin_o
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      AD_WAIT = 3'd1,
      XOR     = 3'd2,
      PAD     = 3'd3,
      PERM    = 3'd4,
      PT_WAIT = 3'd5,
      FIN     = 3'd6
   } fsm_state_t;

   fsm_state_t  fsm;
   logic        in_pt;       // 0 = absorbing AD, 1 = absorbing plaintext
   logic [63:0] blk_data;
   logic        blk_last;
   logic [3:0]  blk_bytes;
   logic [63:0] blk_padded;
   logic [63:0] blk_mask;
   logic        last_full;

   pad_mask u_pad_mask (
      .data   (blk_data),
      .bytes  (blk_bytes),
      .last   (blk_last),
      .padded (blk_padded),
      .mask   (blk_mask)
   );

   // A last block whose mask covers all bytes needs a separate padding step.
   assign last_full = blk_last && (blk_mask == {64{1'b1}});

   // Sequencing of the absorb phases; perm_start_o is a registered pulse.
   always_ff @(posedge clock_i) begin
      if (!resetb_i) begin
         fsm          <= IDLE;
         in_pt        <= 1'b0;
         blk_data     <= '0;
         blk_last     <= 1'b0;
         blk_bytes    <= '0;
         perm_start_o <= 1'b0;
      end else begin
         perm_start_o <= 1'b0;
         case (fsm)
            IDLE: begin
               if (start_i) begin
                  in_pt <= noad_i;
                  fsm   <= noad_i ? PT_WAIT : AD_WAIT;
               end
            end
            AD_WAIT, PT_WAIT: begin
               if (data_valid_i) begin
                  blk_data  <= data_i;
                  blk_last  <= data_last_i;
                  blk_bytes <= data_bytes_i;
                  fsm       <= XOR;
               end
            end
            XOR: begin
               if (last_full) begin
                  fsm <= PAD;
               end else if (in_pt && blk_last) begin
                  fsm <= FIN;
               end else begin
                  fsm          <= PERM;
                  perm_start_o <= 1'b1;
               end
            end
            PAD: begin
               if (in_pt) begin
                  fsm <= FIN;
               end else begin
                  fsm          <= PERM;
                  perm_start_o <= 1'b1;
               end
            end
            PERM: begin
               if (perm_done_i) begin
                  if (!in_pt && blk_last) begin
                     in_pt <= 1'b1;
                     fsm   <= PT_WAIT;
                  end else begin
                     fsm <= in_pt ? PT_WAIT : AD_WAIT;
                  end
               end
            end
            FIN: begin
               in_pt <= 1'b0;
               fsm   <= IDLE;
            end
            default: fsm <= IDLE;
         endcase
      end
   end

   assign data_ready_o   = (fsm == AD_WAIT) || (fsm == PT_WAIT);
   assign cipher_valid_o = (fsm == XOR) && in_pt;
   assign fin_o          = (fsm == FIN);

   // Domain separation is requested on the cycle that commits to the PT phase.
   assign ad_done_o = ((fsm == IDLE) && start_i && noad_i)
                   || ((fsm == PERM) && perm_done_i && !in_pt && blk_last);

   // Ciphertext is the rate word XOR the raw block, cut to the valid bytes.
   assign cipher_o = cipher_valid_o ? ((state_i[0] ^ blk_data) & blk_mask) : '0;

   // State update: pass-through unless absorbing, padding or adding the key.
   always_comb begin
      state_o    = state_i;
      state_we_o = 1'b0;
      case (fsm)
         XOR: begin
            state_we_o = 1'b1;
            state_o[0] = state_i[0] ^ blk_padded;
         end
         PAD: begin
            state_we_o = 1'b1;
            state_o[0] = state_i[0] ^ c_pad_word;
         end
         FIN: begin
            if (FIN_KEY_EN) begin
               state_we_o = 1'b1;
               state_o[1] = state_i[1] ^ key_i[127:64];
               state_o[2] = state_i[2] ^ key_i[63:0];
            end
         end
         default: ;
      endcase
   end

endmodule : data_absorber
`default_nettype wire
